// File: rtl/mips_pipe_ctrl.sv
// mips_pipe_ctrl: decode-once control for a 5-stage MIPS pipeline (F/D/E/M/W).
// Registers a control word plus Tnew through D/E, E/M, M/W; drives stall,
// forwarding selects and stage-local datapath controls. Owns no data values.
// Ports: clk, reset (sync, active-high), instr_D, movz_zero_E in;
//   stall, PCsel_D, EXTop_D, fwd_rs_D/fwd_rt_D (D), ALUctr_E, Bsel_E,
//   fwd_rs_E/fwd_rt_E (E), MemWrite_M, fwd_rt_M (M), RegWrite_W, WDsel_W,
//   A3_W (W) out. Define MDU_EN to add mult/div/mfhi/mflo/mthi/mtlo with
//   a busy counter and the mdu_start_E / mdu_op_E outputs.
module mips_pipe_ctrl #(
  parameter int LOAD_TNEW   = 2,
  parameter int REG_AW      = 5,
  parameter int MDU_LATENCY = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr_D,
  input  logic              movz_zero_E,
  output logic              stall,
  output logic [1:0]        PCsel_D,
  output logic [2:0]        EXTop_D,
  output logic [1:0]        fwd_rs_D,
  output logic [1:0]        fwd_rt_D,
  output logic [2:0]        ALUctr_E,
  output logic              Bsel_E,
  output logic [1:0]        fwd_rs_E,
  output logic [1:0]        fwd_rt_E,
  output logic              MemWrite_M,
  output logic              fwd_rt_M,
  output logic              RegWrite_W,
  output logic [1:0]        WDsel_W,
`ifdef MDU_EN
  output logic              mdu_start_E,
  output logic [2:0]        mdu_op_E,
`endif
  output logic [REG_AW-1:0] A3_W
);

  typedef logic [REG_AW-1:0] reg_t;
  typedef logic [1:0] t_t;

  logic [5:0] op, fn;
  reg_t rs, rt, rd;
  logic rty;

  assign op  = instr_D[31:26];
  assign fn  = instr_D[5:0];
  assign rs  = reg_t'(instr_D[25:21]);
  assign rt  = reg_t'(instr_D[20:16]);
  assign rd  = reg_t'(instr_D[15:11]);
  assign rty = (op == 6'h00);

  logic unused_ok;
  assign unused_ok = ^{instr_D[10:6], MDU_LATENCY[0]};

  logic i_addu, i_subu, i_movz, i_jr, i_jalr;
  logic i_ori, i_xori, i_lui, i_lw, i_sw;
  logic i_beq, i_j, i_jal;

  assign i_addu = rty && fn == 6'h21;
  assign i_subu = rty && fn == 6'h23;
  assign i_movz = rty && fn == 6'h0a;
  assign i_jr   = rty && fn == 6'h08;
  assign i_jalr = rty && fn == 6'h09;
  assign i_ori  = op == 6'h0d;
  assign i_xori = op == 6'h0e;
  assign i_lui  = op == 6'h0f;
  assign i_lw   = op == 6'h23;
  assign i_sw   = op == 6'h2b;
  assign i_beq  = op == 6'h04;
  assign i_j    = op == 6'h02;
  assign i_jal  = op == 6'h03;

`ifdef MDU_EN
  logic i_mult, i_div, i_mfhi, i_mflo, i_mthi, i_mtlo;
  logic [2:0] d_mdu;
  assign i_mult = rty && fn == 6'h18;
  assign i_div  = rty && fn == 6'h1a;
  assign i_mfhi = rty && fn == 6'h10;
  assign i_mflo = rty && fn == 6'h12;
  assign i_mthi = rty && fn == 6'h11;
  assign i_mtlo = rty && fn == 6'h13;
`endif

  reg_t d_a1, d_a2, d_a3;
  t_t d_tu1, d_tu2, d_tnew;
  logic [2:0] d_alu;
  logic [1:0] d_wd;
  logic d_bsel, d_mw, d_movz;

  always_comb begin
    d_a1 = '0;
    d_a2 = '0;
    d_a3 = '0;
    d_tu1 = 2'd3;
    d_tu2 = 2'd3;
    d_tnew = '0;
    d_alu = '0;
    d_wd = '0;
    d_bsel = 1'b0;
    d_mw = 1'b0;
    d_movz = 1'b0;
    PCsel_D = '0;
    EXTop_D = '0;
`ifdef MDU_EN
    d_mdu = '0;
`endif
    unique case (1'b1)
      i_addu, i_subu, i_movz: begin
        d_a1 = rs;
        d_tu1 = 2'd1;
        d_a2 = rt;
        d_tu2 = 2'd1;
        d_a3 = rd;
        d_tnew = 2'd1;
        d_alu = i_subu ? 3'd1 : (i_movz ? 3'd5 : 3'd0);
        d_movz = i_movz;
      end
      i_ori, i_xori: begin
        d_a1 = rs;
        d_tu1 = 2'd1;
        d_a3 = rt;
        d_tnew = 2'd1;
        d_alu = i_ori ? 3'd2 : 3'd4;
        d_bsel = 1'b1;
      end
      i_lui: begin
        d_a3 = rt;
        d_tnew = 2'd1;
        d_alu = 3'd3;
        d_bsel = 1'b1;
        EXTop_D = 3'd1;
      end
      i_lw, i_sw: begin
        d_a1 = rs;
        d_tu1 = 2'd1;
        d_bsel = 1'b1;
        EXTop_D = 3'd2;
        if (i_lw) begin
          d_a3 = rt;
          d_tnew = t_t'(LOAD_TNEW);
          d_wd = 2'd1;
        end else begin
          d_a2 = rt;
          d_tu2 = 2'd2;
          d_mw = 1'b1;
        end
      end
      i_beq: begin
        d_a1 = rs;
        d_tu1 = 2'd0;
        d_a2 = rt;
        d_tu2 = 2'd0;
        PCsel_D = 2'd1;
        EXTop_D = 3'd3;
      end
      i_j: PCsel_D = 2'd1;
      i_jal: begin
        d_a3 = reg_t'(31);
        d_wd = 2'd2;
        PCsel_D = 2'd1;
      end
      i_jr, i_jalr: begin
        d_a1 = rs;
        d_tu1 = 2'd0;
        PCsel_D = 2'd2;
        if (i_jalr) begin
          d_a3 = rd;
          d_wd = 2'd2;
        end
      end
`ifdef MDU_EN
      i_mult, i_div: begin
        d_a1 = rs;
        d_tu1 = 2'd1;
        d_a2 = rt;
        d_tu2 = 2'd1;
        d_mdu = i_mult ? 3'd1 : 3'd2;
      end
      i_mfhi, i_mflo: begin
        d_a3 = rd;
        d_tnew = 2'd1;
        d_mdu = i_mfhi ? 3'd3 : 3'd4;
      end
      i_mthi, i_mtlo: begin
        d_a1 = rs;
        d_tu1 = 2'd1;
        d_mdu = i_mthi ? 3'd5 : 3'd6;
      end
`endif
      default: ;
    endcase
  end

  reg_t a1_e, a2_e, a3_e, a2_m, a3_m, a3_w;
  t_t tnew_e, tnew_m, tnew_w;
  logic [2:0] alu_e;
  logic [1:0] wd_e, wd_m, wd_w;
  logic bsel_e, mw_e, mw_m, movz_e;

  function automatic logic hz(reg_t a, t_t tu, reg_t a3, t_t tn);
    return a != '0 && a == a3 && tu < tn;
  endfunction

  function automatic logic hit(reg_t a, reg_t a3, t_t tn);
    return a != '0 && a == a3 && tn == '0;
  endfunction

  function automatic t_t dec(t_t t);
    return (t == '0) ? '0 : t - 2'd1;
  endfunction

  logic hz_stall;
  assign hz_stall = hz(d_a1, d_tu1, a3_e, tnew_e)
                  | hz(d_a1, d_tu1, a3_m, tnew_m)
                  | hz(d_a2, d_tu2, a3_e, tnew_e)
                  | hz(d_a2, d_tu2, a3_m, tnew_m);

`ifdef MDU_EN
  localparam int CW = $clog2(MDU_LATENCY + 1);
  logic [CW-1:0] cnt;
  logic [2:0] mdu_e;
  assign mdu_op_E = mdu_e;
  assign mdu_start_E = (mdu_e == 3'd1) || (mdu_e == 3'd2);
  assign stall = hz_stall
               | (d_mdu != '0 && (cnt != '0 || mdu_start_E));

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (mdu_start_E)
      cnt <= CW'(MDU_LATENCY);
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end
`else
  assign stall = hz_stall;
`endif

  assign fwd_rs_D = hit(d_a1, a3_e, tnew_e) ? 2'd3 :
                    hit(d_a1, a3_m, tnew_m) ? 2'd2 :
                    hit(d_a1, a3_w, tnew_w) ? 2'd1 : 2'd0;
  assign fwd_rt_D = hit(d_a2, a3_e, tnew_e) ? 2'd3 :
                    hit(d_a2, a3_m, tnew_m) ? 2'd2 :
                    hit(d_a2, a3_w, tnew_w) ? 2'd1 : 2'd0;
  assign fwd_rs_E = hit(a1_e, a3_m, tnew_m) ? 2'd2 :
                    hit(a1_e, a3_w, tnew_w) ? 2'd1 : 2'd0;
  assign fwd_rt_E = hit(a2_e, a3_m, tnew_m) ? 2'd2 :
                    hit(a2_e, a3_w, tnew_w) ? 2'd1 : 2'd0;
  assign fwd_rt_M = hit(a2_m, a3_w, tnew_w);

  assign ALUctr_E   = alu_e;
  assign Bsel_E     = bsel_e;
  assign MemWrite_M = mw_m;
  assign RegWrite_W = a3_w != '0;
  assign WDsel_W    = wd_w;
  assign A3_W       = a3_w;

  // A stall turns the D/E load into a bubble; later stages never hold.
  always_ff @(posedge clk) begin
    if (reset || stall) begin
      a1_e <= '0;
      a2_e <= '0;
      a3_e <= '0;
      tnew_e <= '0;
      alu_e <= '0;
      wd_e <= '0;
      bsel_e <= 1'b0;
      mw_e <= 1'b0;
      movz_e <= 1'b0;
`ifdef MDU_EN
      mdu_e <= '0;
`endif
    end else begin
      a1_e <= d_a1;
      a2_e <= d_a2;
      a3_e <= d_a3;
      tnew_e <= d_tnew;
      alu_e <= d_alu;
      wd_e <= d_wd;
      bsel_e <= d_bsel;
      mw_e <= d_mw;
      movz_e <= d_movz;
`ifdef MDU_EN
      mdu_e <= d_mdu;
`endif
    end
  end

  // movz commits its write only once its condition is known in E.
  always_ff @(posedge clk) begin
    if (reset) begin
      a2_m <= '0;
      a3_m <= '0;
      tnew_m <= '0;
      mw_m <= 1'b0;
      wd_m <= '0;
      a3_w <= '0;
      tnew_w <= '0;
      wd_w <= '0;
    end else begin
      a2_m <= a2_e;
      a3_m <= (movz_e && !movz_zero_E) ? '0 : a3_e;
      tnew_m <= dec(tnew_e);
      mw_m <= mw_e;
      wd_m <= wd_e;
      a3_w <= a3_m;
      tnew_w <= dec(tnew_m);
      wd_w <= wd_m;
    end
  end

endmodule

// File: doc/mips_pipe_ctrl.md
Name: mips_pipe_ctrl

Overview:
- Centralised control for the 5-stage MIPS pipeline (F/D/E/M/W). Replaces per-stage re-decoding: the instruction is decoded once in D, and a control word plus a hazard-timing tag (Tnew) is registered through D/E, E/M and M/W.
- Generates the stall signal, the forwarding mux selects and all stage-local datapath controls.
- Sits beside the datapath; owns no data values.

Parameters:
- LOAD_TNEW, 2, cycles after leaving E until lw data is available (Tnew at E).
- REG_AW, 5, register address width (A1/A2/A3).
- MDU_LATENCY, 5, mult/div busy cycles (used only with MDU_EN).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high; clears all pipeline control registers to nop.
- instr_D  in  32  instruction in D (0 = nop).
- movz_zero_E  in  1  rt operand of E instruction == 0 (forwarded value).
- stall  out  1  hold PC and F/D register; inject bubble into D/E.
- PCsel_D  out  2  0 = ADD4, 1 = NPC, 2 = RFV1.
- EXTop_D  out  3  0 zero-ext, 1 lui, 2 sign-ext, 3 sign-ext<<2.
- fwd_rs_D, fwd_rt_D  out  2 each  0 = RF, 1 = W, 2 = M, 3 = E(PC8).
- ALUctr_E  out  3  0 add, 1 sub, 2 or, 3 B, 4 xor, 5 A.
- Bsel_E  out  1  0 = forwarded rt, 1 = EXT.
- fwd_rs_E, fwd_rt_E  out  2 each  0 = pipeline reg, 1 = W, 2 = M.
- MemWrite_M  out  1  sw in M.
- fwd_rt_M  out  1  0 = pipeline reg, 1 = W.
- RegWrite_W  out  1  register-file write enable.
- WDsel_W  out  2  0 AO, 1 DR, 2 PC8.
- A3_W  out  REG_AW  write register.

Behaviour:
- Decode in D supports addu, subu, ori, xori, lui, lw, sw, beq, j, jal, jr, jalr, movz and nop. Unknown opcodes decode as nop.
- A3 is rd for R-type writers, rt for lw/ori/xori/lui, 31 for jal, and 0 for non-writers. Any write to register 0 is treated as A3 = 0 everywhere.
- Tuse:
  - rs: 0 for beq/jr/jalr, 1 for ALU/lw/sw.
  - rt: 0 for beq, 1 for addu/subu/movz/xori-free R-type, 2 for sw.
  - Non-users: 3 (never stall).
- Tnew when entering E: lw = LOAD_TNEW; ALU writers = 1; jal/jalr = 0.
- Tnew is decremented, saturating at 0, on each transfer E->M and M->W.
- stall = 1 when, for a source with nonzero address A, a stage X in {E, M} holds A3_X == A and Tuse < Tnew_X. This is purely combinational from the registered state.
- On stall: D/E loads nop (all zero, Tnew 0, A3 0). E/M and M/W advance normally.
- Forward priority is the youngest stage first, and a stage is eligible only when it matches A3 (nonzero) and has Tnew == 0. Example: fwd_rs_D = 3 if E matches with Tnew 0; else 2 if M matches; else 1 if W matches; else 0.
- movz: the write is conditional. At the E->M transfer, if movz_zero_E = 0 the M-stage A3 and RegWrite are cleared. Hazard logic in E stays conservative (it assumes the write happens).
- Latency: every control field appears in its stage exactly one cycle after the previous stage. No combinational path from instr_D to any E/M/W output.
- Reset: all stage registers are nop. All outputs are 0 (stall 0, PCsel_D decodes instr_D). Reset mid-stall discards the pending bubble.

Optional Feature:
- Macro: MDU_EN.
- Defined:
  - Adds mult, div, mfhi, mflo, mthi and mtlo.
  - A busy counter loads MDU_LATENCY when mult/div leaves E, and decrements to 0.
  - Adds outputs mdu_start_E (1 bit) and mdu_op_E (3 bits).
  - stall is additionally asserted while an MDU instruction is in D and (counter != 0 or mdu_start_E = 1).
  - mfhi/mflo write with Tnew 1.
- Undefined: these opcodes decode as nop and there is no counter.

Test Plan:
- lw $1,0($0); addu $2,$1,$1 -> stall = 1 for exactly 1 cycle. Next cycle fwd_rs_E = fwd_rt_E = 1 (W). No second stall.
- ori $3,$0,5; beq $3,$3,L -> stall = 1 for 1 cycle. Then fwd_rs_D = fwd_rt_D = 2 (M).
- jal f; jr $31 (in delay slot) -> no stall; fwd_rs_D = 3 (E, PC8). A3_W = 31, WDsel_W = 2 two cycles later.
- movz $4,$5,$6 with movz_zero_E = 0 -> RegWrite_W = 0 and A3_W = 0. With movz_zero_E = 1 -> RegWrite_W = 1 and A3_W = 4.
- addu $0,$1,$1; addu $2,$0,$0 -> no stall, fwd selects are all 0. Assert reset during a stall -> next cycle stall = 0 and all E/M/W outputs are 0.
- (MDU_EN, MDU_LATENCY = 5) mult $1,$2; mflo $3 -> stall is high for 6 cycles, then mflo proceeds.
